alu_acc_seq: RTL and testbench

- Parametrised, registered successor to the 16-bit combinational ALU.
- Adds valid/ready handshakes on operand and result sides, an internal accumulator usable as operand X, and multi-bit shifts done iteratively at one bit per cycle.
- Sits between the operand/op-code source and the result consumer in the datapath; the accumulator replaces the separate output-holding register.

---
 rtl/alu_acc_pkg.sv | 35 +++
 rtl/alu_acc_core.sv | 68 ++++++
 rtl/alu_acc_seq.sv | 163 ++++++++++++++++
 tb/tb_alu_acc_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_acc_pkg
//  Description : Shared types and helpers for the accumulating sequential ALU:
//                op-code and FSM state encodings, shift-amount width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_acc_pkg;

    // Operation codes presented on the op port
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_SHL = 3'b010,
        OP_SHR = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_NOT = 3'b111
    } op_e;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Width of the shift amount / shift counter for a given datapath width
    function automatic int shw_of(input int width);
        return $clog2(width);
    endfunction

endpackage : alu_acc_pkg
`default_nettype wire

// File: rtl/alu_acc_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_acc_core
//  Description : Combinational single-step ALU: ADD/SUB/logic/NOT with
//                sign-magnitude SUB and ADD overflow flag. Shift op-codes
//                pass operand A through (the iterative shifter lives in the
//                sequential wrapper).
//  Config      : ALU_ACC_SAT_EN - ADD overflow saturates to all ones
//                instead of returning zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_acc_core
    import alu_acc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             neg,
    output logic             err
);

    logic [WIDTH:0] w_sum;
    logic           w_a_ge_b;

    assign w_sum    = {1'b0, a} + {1'b0, b};
    assign w_a_ge_b = (a >= b);

    // Single-step result selection; flags default low for every op
    always_comb begin
        result = '0;
        neg    = 1'b0;
        err    = 1'b0;
        case (op_e'(op))
            OP_ADD: begin
                if (w_sum[WIDTH]) begin
                    err = 1'b1;
`ifdef ALU_ACC_SAT_EN
                    result = '1;
`else
                    result = '0;
`endif
                end else begin
                    result = w_sum[WIDTH-1:0];
                end
            end
            OP_SUB: begin
                if (w_a_ge_b) begin
                    result = a - b;
                end else begin
                    result = b - a;
                    neg    = 1'b1;
                end
            end
            OP_SHL,
            OP_SHR:  result = a;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            default: result = '0;
        endcase
    end

endmodule : alu_acc_core
`default_nettype wire

// File: rtl/alu_acc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_acc_seq
//  Description : Registered ALU with valid/ready handshakes, an accumulator
//                selectable as operand X, and bit-serial shifts (one bit per
//                cycle). Non-shift ops complete in one cycle.
//  Config      : ALU_ACC_SAT_EN - ADD overflow saturates and the saturated
//                value is written to the accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_acc_seq
    import alu_acc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             use_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             neg,
    output logic             err,
    output logic [WIDTH-1:0] acc
);

    localparam int SHW = shw_of(WIDTH);

    state_e           r_state;
    state_e           w_state_nxt;

    logic [WIDTH-1:0] r_result;   // doubles as the working register while shifting
    logic             r_neg;
    logic             r_err;
    logic [WIDTH-1:0] r_acc;
    logic [SHW-1:0]   r_cnt;
    logic             r_shl;      // direction of the shift in progress

    logic [WIDTH-1:0] w_opx;
    logic [SHW-1:0]   w_shamt;
    logic             w_accept;
    logic             w_is_shift;
    logic             w_multi_shift;
    logic             w_out_xfer;
    logic [WIDTH-1:0] w_core_result;
    logic             w_core_neg;
    logic             w_core_err;

    assign w_opx         = use_acc ? r_acc : x;
    assign w_shamt       = y[SHW-1:0];
    assign w_accept      = in_valid && in_ready;
    assign w_is_shift    = (op_e'(op) == OP_SHL) || (op_e'(op) == OP_SHR);
    assign w_multi_shift = w_is_shift && (w_shamt != '0);
    assign w_out_xfer    = out_valid && out_ready;

    alu_acc_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op     (op),
        .a      (w_opx),
        .b      (y),
        .result (w_core_result),
        .neg    (w_core_neg),
        .err    (w_core_err)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: shifts with a non-zero amount detour through SHIFT
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_multi_shift ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == SHW'(1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
    end

    // Datapath: capture single-step results, run the serial shifter, and
    // commit the result to the accumulator on the output handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_neg    <= 1'b0;
            r_err    <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_shl    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_result <= w_core_result;
                        r_neg    <= w_core_neg;
                        r_err    <= w_core_err;
                        if (w_multi_shift) begin
                            r_cnt <= w_shamt;
                            r_shl <= (op_e'(op) == OP_SHL);
                        end
                    end
                end
                ST_SHIFT: begin
                    if (r_shl) begin
                        r_result <= {r_result[WIDTH-2:0], 1'b0};
                    end else begin
                        r_result <= {1'b0, r_result[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt - SHW'(1);
                end
                ST_DONE: begin
                    if (out_ready) begin
`ifdef ALU_ACC_SAT_EN
                        r_acc <= r_result;
`else
                        if (!r_err) begin
                            r_acc <= r_result;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign neg    = r_neg;
    assign err    = r_err;
    assign acc    = r_acc;

endmodule : alu_acc_seq
`default_nettype wire

// File: tb/tb_alu_acc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_acc_seq
//  Description : Scoreboard bench for alu_acc_seq (WIDTH=16). Stimulus pushes
//                hand-computed expectations; a monitor pops and compares on
//                every output handshake.
//  Config      : ALU_ACC_SAT_EN - selects saturating ADD expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_acc_seq;

    localparam int WIDTH = 16;

    typedef struct packed {
        logic [15:0] res;
        logic        n;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'b000;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic        use_acc = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic        neg;
    logic        err;
    logic [15:0] acc;

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];

    alu_acc_seq #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .x         (x),
        .y         (y),
        .use_acc   (use_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .neg       (neg),
        .err       (err),
        .acc       (acc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake must match the oldest expectation
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out actual=0x%0h expected=none", result);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_result", {16'h0, result}, {16'h0, e.res});
                chk("sb_neg", {31'h0, neg}, {31'h0, e.n});
                chk("sb_err", {31'h0, err}, {31'h0, e.e});
            end
        end
    end

    // Issue one transaction, check latency, busy in_ready and post-transfer acc
    task automatic issue(input string name, input logic [2:0] o, input logic [15:0] xi,
                         input logic [15:0] yi, input logic ua, input logic [15:0] er,
                         input logic en, input logic ee, input int elat,
                         input logic [15:0] eacc);
        int lat;
        logic busy_bad;
        @(negedge clk);
        chk({name, "_in_ready"}, {31'h0, in_ready}, 32'h1);
        op = o; x = xi; y = yi; use_acc = ua; in_valid = 1'b1;
        sb_q.push_back('{er, en, ee});
        lat = 0;
        busy_bad = 1'b0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            if (in_ready) busy_bad = 1'b1;
        end while (!out_valid && lat < 40);
        chk({name, "_latency"}, lat, elat);
        chk({name, "_busy"}, {31'h0, busy_bad}, 32'h0);
        @(negedge clk);
        chk({name, "_acc"}, {16'h0, acc}, {16'h0, eacc});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ovf_res;
        logic [15:0] ovf_acc;
        logic [15:0] held;
        logic        bp_bad;
        logic        rst_bad;
`ifdef ALU_ACC_SAT_EN
        ovf_res = 16'hFFFF;
        ovf_acc = 16'hFFFF;
`else
        ovf_res = 16'h0000;
        ovf_acc = 16'h0000;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_result", {16'h0, result}, 32'h0);
        chk("rst_flags", {30'h0, neg, err}, 32'h0);
        chk("rst_acc", {16'h0, acc}, 32'h0);

        //     name      op      x        y        ua    result   neg   err  lat  acc
        issue("add_ovf", 3'b000, 16'h0001, 16'hFFFF, 1'b0, ovf_res, 1'b0, 1'b1, 1, ovf_acc);
        issue("sub_neg", 3'b001, 16'h0003, 16'h0008, 1'b0, 16'h0005, 1'b1, 1'b0, 1, 16'h0005);
        issue("sub_pos", 3'b001, 16'h0008, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0, 1, 16'h0005);
        issue("sub_eq",  3'b001, 16'h0007, 16'h0007, 1'b0, 16'h0000, 1'b0, 1'b0, 1, 16'h0000);
        issue("shl4",    3'b010, 16'h0003, 16'h0004, 1'b0, 16'h0030, 1'b0, 1'b0, 5, 16'h0030);
        issue("shr15",   3'b011, 16'h8000, 16'h000F, 1'b0, 16'h0001, 1'b0, 1'b0, 16, 16'h0001);
        issue("shl0",    3'b010, 16'hABCD, 16'h0000, 1'b0, 16'hABCD, 1'b0, 1'b0, 1, 16'hABCD);
        issue("shl_hiy", 3'b010, 16'h0001, 16'h0012, 1'b0, 16'h0004, 1'b0, 1'b0, 3, 16'h0004);
        issue("and",     3'b100, 16'hF0F0, 16'hFF00, 1'b0, 16'hF000, 1'b0, 1'b0, 1, 16'hF000);
        issue("or",      3'b101, 16'h00F0, 16'h0F00, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1, 16'h0FF0);
        issue("not",     3'b111, 16'h1234, 16'h5555, 1'b0, 16'hEDCB, 1'b0, 1'b0, 1, 16'hEDCB);
        issue("add57",   3'b000, 16'h0005, 16'h0007, 1'b0, 16'h000C, 1'b0, 1'b0, 1, 16'h000C);
        issue("add_acc", 3'b000, 16'hFFFF, 16'h0003, 1'b1, 16'h000F, 1'b0, 1'b0, 1, 16'h000F);
        issue("xor_acc", 3'b110, 16'h1111, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b0, 1, 16'h0000);

        // Backpressure: hold the result for 3 cycles while a new request is offered
        @(negedge clk);
        out_ready = 1'b0;
        op = 3'b000; x = 16'h0001; y = 16'h0002; use_acc = 1'b0; in_valid = 1'b1;
        sb_q.push_back('{16'h0003, 1'b0, 1'b0});
        @(negedge clk);
        chk("bp_out_valid", {31'h0, out_valid}, 32'h1);
        held = result;
        op = 3'b110; x = 16'hFFFF; y = 16'h1234;
        bp_bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (!out_valid || in_ready || result !== held) bp_bad = 1'b1;
        end
        chk("bp_hold", {31'h0, bp_bad}, 32'h0);
        chk("bp_result", {16'h0, held}, 32'h3);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_acc", {16'h0, acc}, 32'h3);
        chk("bp_idle", {30'h0, out_valid, in_ready}, 32'h1);
        repeat (3) @(negedge clk);
        chk("bp_sb_empty", sb_q.size(), 0);

        // Reset during a 10-bit shift aborts it without emitting a result
        @(negedge clk);
        op = 3'b010; x = 16'h0001; y = 16'h000A; use_acc = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_out_valid", {31'h0, out_valid}, 32'h0);
        chk("abort_acc", {16'h0, acc}, 32'h0);
        chk("abort_in_ready", {31'h0, in_ready}, 32'h1);
        rst_bad = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) rst_bad = 1'b1;
        end
        chk("abort_no_out", {31'h0, rst_bad}, 32'h0);
        chk("final_sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_acc_seq
`default_nettype wire
